// File: rtl/deemphasis_iir_mc_if.sv
// Bus bundle for the de-emphasis filter: input frame path, coefficients and output frame path.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready are both 1.
// The source holds valid and its payload (in_data, enable, coef_*) stable until that edge.
// The sink may change ready at any time. Payload on the output side (out_data, sat_flag)
// stays stable while out_valid is 1 and out_ready is 0.
interface deemphasis_iir_mc_if #(
   parameter int CH     = 2,
   parameter int W      = 24,
   parameter int COEF_W = 18
);
   logic                     in_valid;
   logic                     in_ready;
   logic [CH*W-1:0]          in_data;
   logic                     enable;
   logic signed [COEF_W-1:0] coef_b0;
   logic signed [COEF_W-1:0] coef_b1;
   logic signed [COEF_W-1:0] coef_a1;
   logic                     out_valid;
   logic                     out_ready;
   logic [CH*W-1:0]          out_data;
   logic                     sat_flag;

   modport master (
      output in_valid, in_data, enable, coef_b0, coef_b1, coef_a1, out_ready,
      input  in_ready, out_valid, out_data, sat_flag
   );

   modport slave (
      input  in_valid, in_data, enable, coef_b0, coef_b1, coef_a1, out_ready,
      output in_ready, out_valid, out_data, sat_flag
   );
endinterface

// File: rtl/deemphasis_iir_mc.sv
// Multi-channel first-order IIR de-emphasis: y = b0*x + b1*x1 - a1*y1 per channel,
// one shared multiplier stepped through 3 phases per channel, with a bypass mode
// that forwards the frame and zeroes the filter history.
module deemphasis_iir_mc #(
   parameter int CH     = 2,
   parameter int W      = 24,
   parameter int COEF_W = 18
) (
   input  logic                 clk,
   input  logic                 rst,
   deemphasis_iir_mc_if.slave   bus,
   output logic [1:0]           o_dbg_state
);

   localparam int FRAC  = COEF_W - 2;
   localparam int P_W   = COEF_W + W;
   localparam int ACC_W = W + COEF_W + 2;
   localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MAC  = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   localparam logic signed [ACC_W-1:0] RND  = {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
   localparam logic [CH_W-1:0]         LAST_CH = CH_W'(CH - 1);

   logic [1:0]               r_state;
   logic [CH_W-1:0]          r_ch;
   logic [1:0]               r_ph;
   logic                     r_in_ready;
   logic                     r_out_valid;
   logic                     r_sat;
   logic signed [ACC_W-1:0]  r_acc;
   logic signed [COEF_W-1:0] r_b0;
   logic signed [COEF_W-1:0] r_b1;
   logic signed [COEF_W-1:0] r_a1;
   logic signed [W-1:0]      r_x  [CH];
   logic signed [W-1:0]      r_x1 [CH];
   logic signed [W-1:0]      r_y1 [CH];
   logic signed [W-1:0]      r_out[CH];

   logic [1:0]               w_nxt_state;
   logic                     w_hs;
   logic                     w_last;
   logic signed [COEF_W-1:0] w_coef;
   logic signed [W-1:0]      w_samp;
   logic signed [P_W-1:0]    w_prod;
   logic signed [ACC_W-1:0]  w_prod_ext;
   logic signed [ACC_W-1:0]  w_acc_fin;
   logic signed [ACC_W-1:0]  w_rnd;
   logic signed [ACC_W-1:0]  w_shr;
   logic signed [W-1:0]      w_res;
   logic                     w_clip;
   logic [CH*W-1:0]          w_out_flat;

   assign w_hs   = (r_state == S_IDLE) && r_in_ready && bus.in_valid;
   assign w_last = (r_ch == LAST_CH) && (r_ph == 2'd2);

   // Next-state decode for the IDLE -> MAC/OUT -> IDLE frame sequence
   always_comb begin
      w_nxt_state = r_state;
      case (r_state)
         S_IDLE:  if (w_hs) w_nxt_state = bus.enable ? S_MAC : S_OUT;
         S_MAC:   if (w_last) w_nxt_state = S_OUT;
         S_OUT:   if (bus.out_ready) w_nxt_state = S_IDLE;
         default: w_nxt_state = S_IDLE;
      endcase
   end

   // Operand select for the shared multiplier: phase 0 b0*x, phase 1 b1*x1, phase 2 a1*y1
   always_comb begin
      w_coef = r_b0;
      w_samp = r_x[r_ch];
      case (r_ph)
         2'd1: begin
            w_coef = r_b1;
            w_samp = r_x1[r_ch];
         end
         2'd2: begin
            w_coef = r_a1;
            w_samp = r_y1[r_ch];
         end
         default: ;
      endcase
   end

   assign w_prod     = P_W'(w_coef) * P_W'(w_samp);
   assign w_prod_ext = ACC_W'(w_prod);
   assign w_acc_fin  = r_acc - w_prod_ext;
   assign w_rnd      = w_acc_fin + RND;
   assign w_shr      = w_rnd >>> FRAC;

   // Round-half-up result clamped to the signed sample range
   always_comb begin
      w_clip = 1'b0;
      w_res  = w_shr[W-1:0];
      if (w_shr > MAXV) begin
         w_clip = 1'b1;
         w_res  = MAXV[W-1:0];
      end else if (w_shr < MINV) begin
         w_clip = 1'b1;
         w_res  = MINV[W-1:0];
      end
   end

   // Control: state register, channel/phase sequencing and handshake flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ch        <= '0;
         r_ph        <= 2'd0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_nxt_state;
         r_in_ready  <= (w_nxt_state == S_IDLE);
         r_out_valid <= (w_nxt_state == S_OUT);
         if (w_hs) begin
            r_ch <= '0;
            r_ph <= 2'd0;
         end else if (r_state == S_MAC) begin
            if (r_ph == 2'd2) begin
               r_ph <= 2'd0;
               r_ch <= r_ch + 1'b1;
            end else begin
               r_ph <= r_ph + 2'd1;
            end
         end
      end
   end

   // Datapath: frame capture, accumulation, per-channel writeback and history update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
         r_sat <= 1'b0;
         r_b0  <= '0;
         r_b1  <= '0;
         r_a1  <= '0;
         for (int c = 0; c < CH; c++) begin
            r_x[c]   <= '0;
            r_x1[c]  <= '0;
            r_y1[c]  <= '0;
            r_out[c] <= '0;
         end
      end else if (w_hs) begin
         r_acc <= '0;
         r_sat <= 1'b0;
         r_b0  <= bus.coef_b0;
         r_b1  <= bus.coef_b1;
         r_a1  <= bus.coef_a1;
         for (int c = 0; c < CH; c++) begin
            r_x[c] <= bus.in_data[c*W +: W];
            // Bypass forwards the frame and restarts the filter from zero history
            if (!bus.enable) begin
               r_out[c] <= bus.in_data[c*W +: W];
               r_x1[c]  <= '0;
               r_y1[c]  <= '0;
            end
         end
      end else if (r_state == S_MAC) begin
         case (r_ph)
            2'd0: r_acc <= w_prod_ext;
            2'd1: r_acc <= r_acc + w_prod_ext;
            default: begin
               r_acc        <= '0;
               r_out[r_ch]  <= w_res;
               r_x1[r_ch]   <= r_x[r_ch];
               r_y1[r_ch]   <= w_res;
               if (w_clip) r_sat <= 1'b1;
            end
         endcase
      end
   end

   // Pack per-channel results into the flat output bus
   always_comb begin
      w_out_flat = '0;
      for (int c = 0; c < CH; c++) w_out_flat[c*W +: W] = r_out[c];
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = w_out_flat;
   assign bus.sat_flag  = r_sat;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_deemphasis_iir_mc.sv
// Bench for deemphasis_iir_mc: vector table of frames checked through an expected-output
// queue, plus hand-written sequences for latency, backpressure and mid-frame reset.
module tb_deemphasis_iir_mc;
   localparam int CH = 2;
   localparam int W = 24;
   localparam int COEF_W = 18;
   localparam int NV = 11;

   logic       clk;
   logic       rst;
   logic [1:0] dbg_state;
   int         n_pass;
   int         n_total;
   int         lat;

   logic [CH*W:0] exp_q[$];

   typedef struct {
      logic en;
      int   b0;
      int   b1;
      int   a1;
      int   in_l;
      int   in_r;
      int   exp_l;
      int   exp_r;
      logic exp_sat;
   } vec_t;

   vec_t vecs[NV];

   deemphasis_iir_mc_if #(.CH(CH), .W(W), .COEF_W(COEF_W)) bus();

   deemphasis_iir_mc #(.CH(CH), .W(W), .COEF_W(COEF_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [CH*W:0] pack_exp(input logic sat, input int l, input int r);
      logic [W-1:0] wl;
      logic [W-1:0] wr;
      wl = W'(l);
      wr = W'(r);
      return {sat, wr, wl};
   endfunction

   // driver: present a frame, wait for acceptance, optionally record the expected output
   task automatic start_frame(input logic en, input int b0, input int b1, input int a1,
                              input int l, input int r, input bit do_push,
                              input logic [CH*W:0] exp);
      bit ok;
      logic [W-1:0] wl;
      logic [W-1:0] wr;
      @(posedge clk);
      #1;
      wl = W'(l);
      wr = W'(r);
      bus.enable   = en;
      bus.coef_b0  = COEF_W'(b0);
      bus.coef_b1  = COEF_W'(b1);
      bus.coef_a1  = COEF_W'(a1);
      bus.in_data  = {wr, wl};
      bus.in_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         @(posedge clk);
         if (do_push) exp_q.push_back(exp);
         #1;
         bus.in_valid = 1'b0;
      end else begin
         n_total++;
         $display("FAIL handshake_timeout: in_ready stayed 0, required 1");
         bus.in_valid = 1'b0;
      end
   endtask

   // count sampling points after the handshake edge until out_valid is seen
   task automatic wait_out(output int l);
      l = -1;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            l = k;
            break;
         end
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
   endtask

   // scoreboard: compare each accepted output frame against the oldest expectation
   always @(negedge clk) begin
      logic [CH*W:0] e;
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 64'(bus.out_data), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("out_data", 64'(bus.out_data), 64'(e[CH*W-1:0]));
            check("sat_flag", 64'(bus.sat_flag), 64'(e[CH*W]));
         end
      end
   end

   initial begin
      n_pass = 0;
      n_total = 0;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.enable    = 1'b0;
      bus.coef_b0   = '0;
      bus.coef_b1   = '0;
      bus.coef_a1   = '0;
      bus.out_ready = 1'b1;

      //            en    b0      b1     a1      in_l     in_r      exp_l    exp_r     sat
      vecs[0]  = '{1'b1, 65536,  0,     0,      1000,    -1000,    1000,    -1000,    1'b0};
      vecs[1]  = '{1'b0, 0,      0,     0,      0,       0,        0,       0,        1'b0};
      vecs[2]  = '{1'b1, 65536,  0,     -32768, 1000,    -1000,    1000,    -1000,    1'b0};
      vecs[3]  = '{1'b1, 65536,  0,     -32768, 1000,    -1000,    1500,    -1500,    1'b0};
      vecs[4]  = '{1'b1, 65536,  0,     -32768, 1000,    -1000,    1750,    -1750,    1'b0};
      vecs[5]  = '{1'b1, 131071, 0,     0,      8388607, -8388608, 8388607, -8388608, 1'b1};
      vecs[6]  = '{1'b1, 131071, 0,     0,      1,       1,        2,       2,        1'b0};
      vecs[7]  = '{1'b1, 32768,  32768, 0,      100,     100,      51,      51,       1'b0};
      vecs[8]  = '{1'b1, 32768,  0,     0,      3,       -3,       2,       -1,       1'b0};
      vecs[9]  = '{1'b0, 0,      0,     0,      1193046, -5,       1193046, -5,       1'b0};
      vecs[10] = '{1'b1, 65536,  65536, -32768, 10,      20,       10,      20,       1'b0};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_data", 64'(bus.out_data), 64'd0);
      check("rst_sat_flag", 64'(bus.sat_flag), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("in_ready_before_clk", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      check("in_ready_after_release", 64'(bus.in_ready), 64'd1);
      check("state_idle", 64'(dbg_state), 64'd0);

      // table-driven frames with out_ready held high
      for (int i = 0; i < NV; i++) begin
         start_frame(vecs[i].en, vecs[i].b0, vecs[i].b1, vecs[i].a1, vecs[i].in_l, vecs[i].in_r,
                     1'b1, pack_exp(vecs[i].exp_sat, vecs[i].exp_l, vecs[i].exp_r));
         wait_out(lat);
         check("latency", 64'(lat), vecs[i].en ? 64'd7 : 64'd1);
      end
      drain();

      // bypass frame under backpressure, then a filter frame from zeroed history
      bus.out_ready = 1'b0;
      start_frame(1'b0, 0, 0, 0, 32'h123456, 32'h00abcd, 1'b1, pack_exp(1'b0, 32'h123456, 32'h00abcd));
      wait_out(lat);
      check("bp_latency", 64'(lat), 64'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_out_valid", 64'(bus.out_valid), 64'd1);
         check("bp_out_data", 64'(bus.out_data), 64'h00abcd_123456);
         check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_out_valid_drop", 64'(bus.out_valid), 64'd0);
      check("bp_popped", 64'(exp_q.size()), 64'd0);
      start_frame(1'b1, 65536, 65536, -32768, 10, 20, 1'b1, pack_exp(1'b0, 10, 20));
      wait_out(lat);
      check("post_bypass_latency", 64'(lat), 64'd7);
      drain();

      // reset during channel 1 MAC aborts the frame and clears history
      start_frame(1'b1, 65536, 0, 0, 77, 88, 1'b0, '0);
      repeat (3) @(posedge clk);
      #1;
      check("pre_abort_state_mac", 64'(dbg_state), 64'd1);
      rst = 1'b1;
      #1;
      check("abort_out_valid", 64'(bus.out_valid), 64'd0);
      check("abort_out_data", 64'(bus.out_data), 64'd0);
      check("abort_sat_flag", 64'(bus.sat_flag), 64'd0);
      check("abort_in_ready", 64'(bus.in_ready), 64'd0);
      check("abort_state_idle", 64'(dbg_state), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      start_frame(1'b1, 65536, 65536, 0, 5, 6, 1'b1, pack_exp(1'b0, 5, 6));
      wait_out(lat);
      check("post_abort_latency", 64'(lat), 64'd7);
      drain();

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation time exceeded, required finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/deemphasis_iir_mc.md
Name: deemphasis_iir_mc

Overview:
Parametrised multi-channel first-order IIR de-emphasis filter. It implements y[n] = b0*x[n] + b1*x[n-1] - a1*y[n-1] with runtime-programmable coefficients, so 32/44.1/48 kHz 50/15 us curves are supported from one block. A single multiplier is time-multiplexed across all channels under an FSM. The block sits between the digital-input sample path and the interpolator, with valid/ready handshakes on both sides.

Parameters:
CH, 2, number of audio channels (1..8)
W, 24, sample width, signed two's complement
COEF_W, 18, coefficient width, signed Q2.(COEF_W-2); FRAC = COEF_W-2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input frame valid
in_ready  out  1  block can accept a frame
in_data  in  CH*W  channel c at bits [c*W +: W]
enable  in  1  1 = filter, 0 = bypass; sampled at input handshake
coef_b0  in  COEF_W  feed-forward tap 0; sampled at input handshake
coef_b1  in  COEF_W  feed-forward tap 1; sampled at input handshake
coef_a1  in  COEF_W  feedback tap; sampled at input handshake
out_valid  out  1  output frame valid
out_ready  in  1  downstream accepts
out_data  out  CH*W  filtered frame, same packing as in_data
sat_flag  out  1  sticky per-frame flag: any channel saturated in the presented frame

Behaviour:
- Reset (async, rst=1): FSM goes to IDLE. in_ready=0 while rst asserted, 1 from the first clock after release. out_valid=0, out_data=0, sat_flag=0. All x1[c], y1[c] history registers and the accumulator are cleared. A reset during MAC or OUT aborts the frame; no partial output is produced.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_data, coefficients and enable. If enable=1 go to MAC. If enable=0, load out_data=in_data, clear all x1/y1, and go to OUT.
  - MAC: 3*CH cycles. Channel c, phase p=0,1,2 multiplies b0*x, b1*x1[c], a1*y1[c] respectively. Phase 2 subtracts its product. Channels are processed in order 0..CH-1. After phase 2 of a channel, round/saturate the result into out_data[c], then update x1[c]=x and y1[c]=the saturated result. After the last channel go to OUT.
  - OUT: out_valid=1, with out_data and sat_flag held stable. On out_ready, the next state is IDLE and out_valid drops on that edge. in_ready=0 in MAC and OUT; there is no overlap of frames.
- Latency, with the handshake edge as cycle 0:
  - Filter mode: out_valid rises at cycle 3*CH+1.
  - Bypass mode: out_valid rises at cycle 1.
- Arithmetic:
  - Products are full COEF_W+W bits; the accumulator is W+COEF_W+2 bits signed.
  - Result = (acc + 2^(FRAC-1)) >>> FRAC, i.e. round-half-up.
  - The result clamps to [-2^(W-1), 2^(W-1)-1]; clamping sets sat_flag for that frame.
  - y1 stores the clamped value.
- Coefficient or enable changes only take effect at a frame handshake. Switching bypass back to filter resumes from zeroed history, with no stale transient.
- out_ready may be held high permanently: the block then runs at one frame per 3*CH+2 cycles in filter mode.
- in_valid asserted while in_ready=0 is ignored. The source must hold the frame until it is accepted.

Test Plan:
- Reset release, CH=2, W=24, COEF_W=18 -> in_ready=1 one cycle after rst falls; out_valid=0, out_data=0, sat_flag=0.
- Identity filter: b0=65536, b1=0, a1=0, enable=1, input L=1000, R=-1000 -> out L=1000, R=-1000, out_valid at cycle 7 after handshake, sat_flag=0.
- Feedback step: b0=65536, b1=0, a1=-32768 (-0.5), constant L=1000 for 3 frames -> L outputs 1000, 1500, 1750.
- Saturation: b0=131071 (~2.0), L=8388607, R=-8388608 -> L=8388607, R=-8388608, sat_flag=1; next frame with L=R=1 -> sat_flag=0.
- Bypass and backpressure: enable=0, L=0x123456, out_ready=0 for 5 cycles -> out_valid at cycle 1, data held stable, in_ready=0 throughout; frame completes on the out_ready cycle. A following filter frame starts with x1=y1=0.
- Mid-frame reset: assert rst during MAC phase of channel 1 -> outputs zero immediately. After release, the identity frame L=5 yields 5, with no history from the aborted frame.
